result_packer: RTL and testbench

Result drain for the convolution accelerator. Consumes the accelerator's 32-bit result stream (`valid`/`data_out`, with `done` ending a job) and packs four results into 128-bit beats, the same width as the accelerator's input bus. Completed beats are buffered in a small FIFO and handed to the host side over a valid/ready handshake. Partial final beats are zero-padded and flagged with a lane mask.

---
 rtl/acc_pkg.sv | 25 ++
 rtl/result_packer_if.sv | 26 ++
 rtl/beat_fifo.sv | 50 +++++
 rtl/result_packer.sv | 116 +++++++++++
 tb/tb_result_packer.sv | 208 ++++++++++++++++++++
 5 files changed

// File: rtl/acc_pkg.sv
// Shared types and widths for the accelerator result path.
package acc_pkg;

    localparam int ACC_WORD_W = 32;
    localparam int ACC_BUS_W  = 128;
    localparam int LANES      = 4;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACTIVE = 2'd1,
        DRAIN  = 2'd2
    } state_t;

    typedef struct packed {
        logic                 last;
        logic [LANES-1:0]     keep;
        logic [ACC_BUS_W-1:0] data;
    } beat_t;

    // Mask with the low n lanes set, n in 0..LANES.
    function automatic logic [LANES-1:0] lane_mask(input logic [2:0] n);
        lane_mask = LANES'((5'd1 << n) - 5'd1);
    endfunction

endpackage

// File: rtl/result_packer_if.sv
// Accelerator result stream in, packed 128-bit beat stream out, plus status.
interface result_packer_if;
    import acc_pkg::*;

    logic                  acc_valid;
    logic [ACC_WORD_W-1:0] acc_data;
    logic                  acc_done;
    logic                  out_valid;
    logic                  out_ready;
    logic [ACC_BUS_W-1:0]  out_data;
    logic [LANES-1:0]      out_keep;
    logic                  out_last;
    logic                  busy;
    logic                  overflow;

    modport master (
        input  acc_valid, acc_data, acc_done, out_ready,
        output out_valid, out_data, out_keep, out_last, busy, overflow
    );

    modport slave (
        output acc_valid, acc_data, acc_done, out_ready,
        input  out_valid, out_data, out_keep, out_last, busy, overflow
    );

endinterface

// File: rtl/beat_fifo.sv
// First-word-fall-through beat FIFO; a push shows at the head the cycle after its edge.
// Full push is accepted only when a pop happens the same edge; no empty bypass.
module beat_fifo
    import acc_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   push,
    input  beat_t                  push_dat,
    output logic                   full,
    input  logic                   pop,
    output beat_t                  pop_dat,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count
);

    localparam int AW = $clog2(DEPTH);

    beat_t         mem [DEPTH];
    logic [AW:0]   wr_ptr;
    logic [AW:0]   rd_ptr;
    logic          push_ok;
    logic          pop_ok;

    // Extra MSB on each pointer separates full from empty when the indices match.
    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign count   = wr_ptr - rd_ptr;
    assign pop_ok  = pop && !empty;
    assign push_ok = push && (!full || pop_ok);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + 1'b1;
            if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) mem[wr_ptr[AW-1:0]] <= push_dat;
    end

    assign pop_dat = empty ? '0 : mem[rd_ptr[AW-1:0]];

endmodule

// File: rtl/result_packer.sv
// Packs 32-bit accelerator results into 128-bit beats; beat visible the cycle after its push.
// Host stalls are absorbed by the FIFO only; a push into a full, non-popping FIFO is dropped.
module result_packer
    import acc_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int LANES = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    result_packer_if.master        bus
);

    localparam int CW = $clog2(DEPTH) + 1;

    state_t                          state;
    state_t                          state_nxt;
    logic [1:0]                      idx;
    logic [LANES-1:0][ACC_WORD_W-1:0] lanes_q;
    logic [LANES-1:0][ACC_WORD_W-1:0] lanes_wr;
    logic                            push;
    logic                            push_ok;
    logic                            pop;
    beat_t                           push_beat;
    beat_t                           head;
    logic                            fifo_full;
    logic                            fifo_empty;
    logic [CW-1:0]                   fifo_count;
    logic [CW-1:0]                   count_after;
    logic                            overflow_q;

    // A word and done in the same cycle land in the same terminating beat.
    always_comb begin
        lanes_wr  = lanes_q;
        push_beat = '0;
        if (bus.acc_valid) lanes_wr[idx] = bus.acc_data;
        push           = (bus.acc_valid && (idx == 2'd3)) || bus.acc_done;
        push_beat.data = lanes_wr;
        push_beat.last = bus.acc_done;
        push_beat.keep = bus.acc_valid ? lane_mask({1'b0, idx} + 3'd1)
                                       : lane_mask({1'b0, idx});
    end

    assign pop         = bus.out_valid && bus.out_ready;
    assign push_ok     = push && (!fifo_full || pop);
    assign count_after = fifo_count + CW'(push_ok) - CW'(pop);

    // Every push restarts assembly from a cleared register, so padding lanes read as zero.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            idx     <= 2'd0;
            lanes_q <= '0;
        end else if (push) begin
            idx     <= 2'd0;
            lanes_q <= '0;
        end else if (bus.acc_valid) begin
            idx     <= idx + 2'd1;
            lanes_q <= lanes_wr;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            overflow_q <= 1'b0;
        end else if (push && fifo_full && !pop) begin
            overflow_q <= 1'b1;
        end
    end

    beat_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk      (clk),
        .rst      (rst),
        .push     (push),
        .push_dat (push_beat),
        .full     (fifo_full),
        .pop      (pop),
        .pop_dat  (head),
        .empty    (fifo_empty),
        .count    (fifo_count)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // An empty job (done from IDLE) goes straight to DRAIN since its beat is already pushed.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (push && bus.acc_done)  state_nxt = DRAIN;
                else if (bus.acc_valid)    state_nxt = ACTIVE;
            end
            ACTIVE: begin
                if (push && bus.acc_done)  state_nxt = DRAIN;
            end
            DRAIN: begin
                if (push && bus.acc_done)  state_nxt = DRAIN;
                else if (bus.acc_valid)    state_nxt = ACTIVE;
                else if (count_after == '0) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        bus.busy      = (state != IDLE);
        bus.overflow  = overflow_q;
        bus.out_valid = !fifo_empty;
        bus.out_data  = head.data;
        bus.out_keep  = head.keep;
        bus.out_last  = head.last;
    end

endmodule

// File: tb/tb_result_packer.sv
// Scoreboard bench for result_packer: stimulus queues expected beats, a monitor pops and compares.
module tb_result_packer;
    import acc_pkg::*;

    localparam int DEPTH = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    result_packer_if bus();

    result_packer #(.DEPTH(DEPTH), .LANES(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    beat_t exp_q[$];
    int    tests = 0;
    int    fails = 0;

    task automatic check(input string name, input logic [132:0] act, input logic [132:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic beat_t mk(input logic [31:0] w3, input logic [31:0] w2,
                                 input logic [31:0] w1, input logic [31:0] w0,
                                 input logic [3:0] keep, input logic last);
        beat_t b;
        b.data = {w3, w2, w1, w0};
        b.keep = keep;
        b.last = last;
        return b;
    endfunction

    task automatic cyc(input logic v, input logic [31:0] d, input logic done);
        bus.acc_valid = v;
        bus.acc_data  = d;
        bus.acc_done  = done;
        @(posedge clk);
        #1;
        bus.acc_valid = 1'b0;
        bus.acc_data  = 32'h0;
        bus.acc_done  = 1'b0;
    endtask

    task automatic send_beat(input logic [31:0] base, input logic done, input logic expect_it);
        if (expect_it) exp_q.push_back(mk(base + 3, base + 2, base + 1, base, 4'hF, done));
        for (int w = 0; w < 4; w++) cyc(1'b1, base + 32'(w), done && (w == 3));
    endtask

    task automatic wait_drain(input string name);
        int n = 0;
        while ((exp_q.size() != 0 || bus.out_valid) && n < 50) begin
            @(posedge clk);
            #1;
            n++;
        end
        check(name, exp_q.size(), 0);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_out_valid"}, bus.out_valid, 0);
        check({tag, "_out_data"},  bus.out_data,  0);
        check({tag, "_out_keep"},  bus.out_keep,  0);
        check({tag, "_out_last"},  bus.out_last,  0);
        check({tag, "_busy"},      bus.busy,      0);
        check({tag, "_overflow"},  bus.overflow,  0);
    endtask

    // Mid-cycle async reset; the scoreboard forgets everything the DUT discards.
    task automatic async_reset(input logic chk);
        #2;
        rst = 1'b1;
        exp_q.delete();
        #1;
        if (chk) check_all_zero("async_rst");
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    initial begin
        beat_t cur;
        beat_t held;
        beat_t exp;
        logic  stall;
        stall = 1'b0;
        held  = '0;
        forever begin
            @(negedge clk);
            if (rst) begin
                stall = 1'b0;
            end else begin
                cur = {bus.out_last, bus.out_keep, bus.out_data};
                if (stall && bus.out_valid) check("hold_stable", cur, held);
                if (bus.out_valid && bus.out_ready) begin
                    if (exp_q.size() == 0) begin
                        tests++;
                        fails++;
                        $display("FAIL unexpected_beat: got %h expected no beat", cur);
                    end else begin
                        exp = exp_q.pop_front();
                        check("beat", cur, exp);
                    end
                end
                stall = bus.out_valid && !bus.out_ready;
                held  = cur;
            end
        end
    end

    initial begin
        #50000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "timeout");
    end

    initial begin
        bus.acc_valid = 1'b0;
        bus.acc_data  = 32'h0;
        bus.acc_done  = 1'b0;
        bus.out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_all_zero("reset");
        rst = 1'b0;
        @(posedge clk);
        #1;

        // Two full beats, job ends with word 8.
        bus.out_ready = 1'b1;
        send_beat(32'd1, 1'b0, 1'b1);
        send_beat(32'd5, 1'b1, 1'b1);
        wait_drain("drain_full");
        check("busy_after_full_job", bus.busy, 0);

        // Partial final beat: A,B,C then done alone.
        cyc(1'b1, 32'hA, 1'b0);
        cyc(1'b1, 32'hB, 1'b0);
        cyc(1'b1, 32'hC, 1'b0);
        exp_q.push_back(mk(32'h0, 32'hC, 32'hB, 32'hA, 4'b0111, 1'b1));
        cyc(1'b0, 32'h0, 1'b1);
        check("partial_valid", bus.out_valid, 1);
        check("partial_busy_before_pop", bus.busy, 1);
        @(posedge clk);
        #1;
        check("partial_busy_after_pop", bus.busy, 0);

        // Empty job from IDLE.
        exp_q.push_back(mk(32'h0, 32'h0, 32'h0, 32'h0, 4'b0000, 1'b1));
        cyc(1'b0, 32'h0, 1'b1);
        wait_drain("drain_empty_job");
        check("busy_after_empty_job", bus.busy, 0);

        // Backpressure: five beats into a four-deep FIFO, fifth is dropped.
        bus.out_ready = 1'b0;
        for (int b = 0; b < 5; b++) begin
            send_beat(32'h100 * 32'(b + 1), 1'b0, b < 4);
            if (b == 3) check("no_overflow_at_4", bus.overflow, 0);
        end
        check("overflow_set", bus.overflow, 1);
        bus.out_ready = 1'b1;
        wait_drain("drain_overflow");
        check("overflow_sticky", bus.overflow, 1);

        async_reset(1'b0);
        check("overflow_cleared", bus.overflow, 0);

        // Full FIFO with a simultaneous pop and push.
        bus.out_ready = 1'b0;
        for (int b = 0; b < 4; b++) send_beat(32'h1000 * 32'(b + 1), 1'b0, 1'b1);
        exp_q.push_back(mk(32'h5003, 32'h5002, 32'h5001, 32'h5000, 4'hF, 1'b1));
        cyc(1'b1, 32'h5000, 1'b0);
        cyc(1'b1, 32'h5001, 1'b0);
        cyc(1'b1, 32'h5002, 1'b0);
        check("full_before_pushpop", dut.u_fifo.count, 4);
        bus.out_ready = 1'b1;
        cyc(1'b1, 32'h5003, 1'b1);
        check("full_pushpop_count", dut.u_fifo.count, 4);
        check("full_pushpop_no_overflow", bus.overflow, 0);
        wait_drain("drain_pushpop");
        check("busy_after_pushpop", bus.busy, 0);

        // Reset in the middle of a job with a beat waiting at the head.
        bus.out_ready = 1'b0;
        send_beat(32'h6000, 1'b0, 1'b1);
        cyc(1'b1, 32'h7000, 1'b0);
        cyc(1'b1, 32'h7001, 1'b0);
        check("pre_reset_valid", bus.out_valid, 1);
        async_reset(1'b1);
        bus.out_ready = 1'b1;
        send_beat(32'd9, 1'b0, 1'b1);
        exp_q.push_back(mk(32'h0, 32'h0, 32'h0, 32'h0, 4'b0000, 1'b1));
        cyc(1'b0, 32'h0, 1'b1);
        wait_drain("drain_after_reset");
        check("busy_end", bus.busy, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
